// File: rtl/mersenne_pkg.sv
// Shared types and helpers for the Mersenne modular squarer.
package mersenne_pkg;

   typedef enum logic [2:0] {
      IDLE,
      MUL,
      FOLD1,
      FOLD2,
      FIN,
      DONE
   } state_t;

   localparam int unsigned MASK_MAX = 128;

   function automatic logic digit_ok(input int unsigned width, input int unsigned digit);
      return (digit != 0) && ((digit & (digit - 1)) == 0) && ((width % digit) == 0);
   endfunction

   function automatic logic [MASK_MAX-1:0] mersenne_mask(input int unsigned p);
      logic [MASK_MAX-1:0] one;
      one = MASK_MAX'(1);
      return (one << p) - one;
   endfunction

endpackage

// File: rtl/mersenne_fold.sv
// One Mersenne folding step: (v & M) + (v >> p), truncated to WIDTH+1 bits.
module mersenne_fold #(
   parameter int WIDTH = 32,
   parameter int VW    = 64,
   parameter int PW    = 6
) (
   input  logic [VW-1:0]  v,
   input  logic [PW-1:0]  p,
   input  logic [WIDTH:0] mask,
   output logic [WIDTH:0] f
);

   localparam int FW = WIDTH + 1;

   logic [VW-1:0] lo;
   logic [VW-1:0] hi;

   always_comb begin
      lo = v & VW'(mask);
      hi = v >> p;
      f  = FW'(lo + hi);
   end

endmodule

// File: rtl/mersenne_sqr_mod.sv
// Multi-cycle (x*x - 2*sub2) mod (2^p - 1) with runtime p and digit-serial multiply.
module mersenne_sqr_mod
   import mersenne_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int DIGIT = 4,
   localparam int PW = $clog2(WIDTH + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_x,
   input  logic [PW-1:0]    in_p,
   input  logic             in_sub2,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_y,
   output logic             out_err,
   output logic             busy
);

   localparam int NDIG = WIDTH / DIGIT;
   localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;
   localparam int AW   = 2 * WIDTH;
   localparam int FW   = WIDTH + 1;

   if (!digit_ok(WIDTH, DIGIT)) begin : g_bad_digit
      $error("DIGIT must be a power of two that divides WIDTH");
   end
   if (WIDTH + 1 > MASK_MAX) begin : g_bad_width
      $error("WIDTH exceeds mask helper range");
   end

   state_t           state;
   logic [WIDTH-1:0] xm;
   logic [WIDTH-1:0] xs;
   logic [PW-1:0]    p_r;
   logic             sub2_r;
   logic [CW-1:0]    cnt;
   logic [AW-1:0]    acc;
   logic [FW-1:0]    t;

   logic [WIDTH-1:0] in_mask;
   logic             in_legal;
   logic [FW-1:0]    mask;
   logic [DIGIT-1:0] d;
   logic [AW-1:0]    prod;
   logic [AW-1:0]    fold_in;
   logic [FW-1:0]    fold_out;
   logic [FW-1:0]    r;
   logic [FW-1:0]    y_full;

   always_comb begin
      in_mask  = WIDTH'(mersenne_mask(32'(in_p)));
      in_legal = (32'(in_p) >= 32'd2) && (32'(in_p) <= 32'(WIDTH));
      mask     = FW'(mersenne_mask(32'(p_r)));
      // xs is a shifting copy of xm so the active digit is always its top slice
      d        = xs[WIDTH-1 -: DIGIT];
      prod     = AW'(xm) * AW'(d);
      fold_in  = (state == FOLD2) ? AW'(t) : acc;
      r        = (t == mask) ? '0 : t;
      if (!sub2_r) begin
         y_full = r;
      end else if (r >= FW'(2)) begin
         y_full = r - FW'(2);
      end else begin
         y_full = r + mask - FW'(2);
      end
   end

   // Single fold unit shared between FOLD1 (on acc) and FOLD2 (on t)
   mersenne_fold #(
      .WIDTH (WIDTH),
      .VW    (AW),
      .PW    (PW)
   ) u_fold (
      .v    (fold_in),
      .p    (p_r),
      .mask (mask),
      .f    (fold_out)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         out_y     <= '0;
         out_err   <= 1'b0;
         busy      <= 1'b0;
         xm        <= '0;
         xs        <= '0;
         p_r       <= '0;
         sub2_r    <= 1'b0;
         cnt       <= '0;
         acc       <= '0;
         t         <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid && in_ready) begin
                  xm       <= in_x & in_mask;
                  xs       <= in_x & in_mask;
                  p_r      <= in_p;
                  sub2_r   <= in_sub2;
                  acc      <= '0;
                  cnt      <= CW'(NDIG - 1);
                  in_ready <= 1'b0;
                  busy     <= 1'b1;
                  if (in_legal) begin
                     state <= MUL;
                  end else begin
                     state     <= DONE;
                     out_y     <= '0;
                     out_err   <= 1'b1;
                     out_valid <= 1'b1;
                  end
               end
            end
            MUL: begin
               acc <= (acc << DIGIT) + prod;
               xs  <= xs << DIGIT;
               if (cnt == '0) begin
                  state <= FOLD1;
               end else begin
                  cnt <= cnt - CW'(1);
               end
            end
            FOLD1: begin
               t     <= fold_out;
               state <= FOLD2;
            end
            FOLD2: begin
               t     <= fold_out;
               state <= FIN;
            end
            FIN: begin
               out_y     <= WIDTH'(y_full);
               out_err   <= 1'b0;
               out_valid <= 1'b1;
               state     <= DONE;
            end
            DONE: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  busy      <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mersenne_sqr_mod.sv
// Self-checking bench: directed LL vectors, stalls, mid-op reset and random requests.
module tb_mersenne_sqr_mod;

   localparam int WIDTH = 32;
   localparam int DIGIT = 4;
   localparam int PW    = 6;
   localparam int LAT   = WIDTH / DIGIT + 3;

   logic             clk;
   logic             rst_n;
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_x;
   logic [PW-1:0]    in_p;
   logic             in_sub2;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_y;
   logic             out_err;
   logic             busy;

   mersenne_sqr_mod #(
      .WIDTH (WIDTH),
      .DIGIT (DIGIT)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_x      (in_x),
      .in_p      (in_p),
      .in_sub2   (in_sub2),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_y     (out_y),
      .out_err   (out_err),
      .busy      (busy)
   );

   typedef struct {
      logic [31:0] y;
      logic        err;
      int          acc;
   } exp_t;

   typedef struct {
      logic [31:0] x;
      int          p;
      logic        sub2;
      logic [31:0] y;
      logic        err;
   } vec_t;

   exp_t q[$];
   vec_t tbl[$];
   int   n_cmp = 0;
   int   n_bad = 0;
   int   cyc = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   task automatic fail_now(input string name);
      n_cmp++;
      n_bad++;
      $display("FAIL %s: got timeout/unexpected expected normal progress", name);
   endtask

   function automatic logic model_err(input int p);
      return (p < 2) || (p > WIDTH);
   endfunction

   // Reference: plain modular arithmetic on 64-bit integers
   function automatic logic [31:0] model_y(input logic [31:0] x, input int p, input logic sub2);
      logic [63:0] m, xm, r;
      if (model_err(p)) return 32'd0;
      m  = (64'd1 << p) - 64'd1;
      xm = {32'd0, x} & m;
      r  = (xm * xm) % m;
      if (sub2) r = (r + m - 64'd2) % m;
      return r[31:0];
   endfunction

   // Compare process: checks every cycle a result is presented
   logic seen = 1'b0;
   logic hs_prev = 1'b0;
   always @(negedge clk) begin
      if (!rst_n) begin
         seen    = 1'b0;
         hs_prev = 1'b0;
      end else begin
         if (hs_prev) begin
            chk("in_ready_after_hs", 64'(in_ready), 64'd1);
            chk("valid_drop_after_hs", 64'(out_valid), 64'd0);
         end
         hs_prev = 1'b0;
         if (seen && !out_valid) begin
            fail_now("valid_dropped_early");
            seen = 1'b0;
         end
         if (out_valid) begin
            if (q.size() == 0) begin
               fail_now("spurious_valid");
            end else begin
               chk("out_y", 64'(out_y), 64'(q[0].y));
               chk("out_err", 64'(out_err), 64'(q[0].err));
               chk("in_ready_while_valid", 64'(in_ready), 64'd0);
               chk("busy_while_valid", 64'(busy), 64'd1);
               if (!seen) chk("latency", 64'(cyc - q[0].acc), q[0].err ? 64'd0 : 64'(LAT));
               seen = 1'b1;
               if (out_ready) begin
                  void'(q.pop_front());
                  seen    = 1'b0;
                  hs_prev = 1'b1;
               end
            end
         end
      end
   end

   task automatic send(input logic [31:0] x, input int p, input logic sub2,
                       input logic [31:0] ey, input logic eerr, input int stall);
      exp_t e;
      int   n;
      n = 0;
      while (!in_ready && n < 60) begin
         @(posedge clk);
         #1;
         n++;
      end
      if (!in_ready) begin
         fail_now("in_ready_timeout");
         return;
      end
      in_valid  = 1'b1;
      in_x      = x;
      in_p      = PW'(p);
      in_sub2   = sub2;
      out_ready = (stall == 0);
      @(posedge clk);
      #1;
      e.y   = ey;
      e.err = eerr;
      e.acc = cyc;
      q.push_back(e);
      in_valid = 1'b0;
      in_x     = $urandom;
      in_p     = PW'($urandom_range(0, 63));
      in_sub2  = 1'($urandom_range(0, 1));
      if (stall > 0) begin
         n = 0;
         while (!out_valid && n < 40) begin
            @(posedge clk);
            #1;
            n++;
         end
         if (!out_valid) fail_now("out_valid_timeout");
         repeat (stall) @(posedge clk);
         #1;
         out_ready = 1'b1;
      end
   endtask

   initial begin
      in_valid  = 1'b0;
      in_x      = '0;
      in_p      = '0;
      in_sub2   = 1'b0;
      out_ready = 1'b1;
      rst_n     = 1'b1;
      #2 rst_n = 1'b0;
      #2;
      chk("rst_in_ready", 64'(in_ready), 64'd1);
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_out_y", 64'(out_y), 64'd0);
      chk("rst_out_err", 64'(out_err), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      @(posedge clk);
      @(posedge clk);
      #1 rst_n = 1'b1;

      tbl.push_back('{32'd4,   7, 1'b1, 32'd14,  1'b0});
      tbl.push_back('{32'd14,  7, 1'b1, 32'd67,  1'b0});
      tbl.push_back('{32'd67,  7, 1'b1, 32'd42,  1'b0});
      tbl.push_back('{32'd42,  7, 1'b1, 32'd111, 1'b0});
      tbl.push_back('{32'd111, 7, 1'b1, 32'd0,   1'b0});
      tbl.push_back('{32'd1,   7, 1'b1, 32'd126, 1'b0});
      tbl.push_back('{32'd127, 7, 1'b1, 32'd125, 1'b0});
      tbl.push_back('{32'd1,   7, 1'b0, 32'd1,   1'b0});
      tbl.push_back('{32'd127, 7, 1'b0, 32'd0,   1'b0});
      tbl.push_back('{32'hFFFFFFFE, 32, 1'b0, 32'd1, 1'b0});
      tbl.push_back('{32'hFFFFFFFF, 32, 1'b0, 32'd0, 1'b0});
      tbl.push_back('{32'h00010000, 32, 1'b0, 32'd1, 1'b0});
      tbl.push_back('{32'd5,   1, 1'b0, 32'd0,   1'b1});
      tbl.push_back('{32'd5,  33, 1'b1, 32'd0,   1'b1});
      tbl.push_back('{32'd9,   0, 1'b0, 32'd0,   1'b1});
      tbl.push_back('{32'd3,   7, 1'b0, 32'd9,   1'b0});
      tbl.push_back('{32'h183, 7, 1'b0, 32'd9,   1'b0});
      tbl.push_back('{32'd2,   2, 1'b0, 32'd1,   1'b0});
      tbl.push_back('{32'd1,   2, 1'b1, 32'd2,   1'b0});

      foreach (tbl[i]) begin
         chk("model_pin", 64'(model_y(tbl[i].x, tbl[i].p, tbl[i].sub2)), 64'(tbl[i].y));
         send(tbl[i].x, tbl[i].p, tbl[i].sub2, tbl[i].y, tbl[i].err, 0);
      end

      // Consumer stalls for several cycles in DONE
      send(32'd5, 7, 1'b0, 32'd25, 1'b0, 5);

      // Abort a request with reset during its 4th MUL cycle
      for (int n = 0; n < 60 && !in_ready; n++) begin
         @(posedge clk);
         #1;
      end
      in_valid = 1'b1;
      in_x     = 32'd50;
      in_p     = PW'(7);
      in_sub2  = 1'b0;
      @(posedge clk);
      #1 in_valid = 1'b0;
      repeat (3) @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("abort_in_ready", 64'(in_ready), 64'd1);
      chk("abort_out_valid", 64'(out_valid), 64'd0);
      chk("abort_out_y", 64'(out_y), 64'd0);
      chk("abort_out_err", 64'(out_err), 64'd0);
      chk("abort_busy", 64'(busy), 64'd0);
      q.delete();
      @(posedge clk);
      #1 rst_n = 1'b1;
      send(32'd4, 7, 1'b1, 32'd14, 1'b0, 0);

      for (int k = 0; k < 40; k++) begin
         logic [31:0] x;
         int          p;
         logic        s;
         x = $urandom;
         p = (k % 8 == 7) ? int'($urandom_range(0, 40)) : int'($urandom_range(2, 32));
         s = 1'($urandom_range(0, 1));
         send(x, p, s, model_y(x, p, s), model_err(p), int'($urandom_range(0, 3)));
      end

      for (int n = 0; n < 100 && q.size() != 0; n++) @(posedge clk);
      if (q.size() != 0) fail_now("drain_timeout");
      @(posedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
